// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Optional parity support is selected with UART_SEND_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        START_LVL = 1'b0;
  localparam logic        STOP_LVL  = 1'b1;

  // Clocks per bit, integer-truncated.
  function automatic int unsigned calc_bps_cnt(input int unsigned clk_freq,
                                               input int unsigned bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Depth x 8 byte FIFO with occupancy counter; pushes while full and pops while empty are ignored.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == (PtrW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // Depth is a power of two, so pointers wrap by natural overflow.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_send_buf.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serialiser.
// Define UART_SEND_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_send_buf
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned UART_BPS   = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned BPS_CNT  = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam logic [15:0] BpsLast  = 16'(BPS_CNT - 1);
  localparam logic [2:0]  LastBit  = 3'(DATA_BITS - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic        txd_q, txd_d;
  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_data;
  logic        period_end;
`ifdef UART_SEND_PARITY_EN
  logic        par_q, par_d;
`endif

  uart_byte_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .push_i  (tx_valid),
    .data_i  (tx_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign period_end = (clk_cnt_q == BpsLast);
  assign tx_ready   = !fifo_full;
  assign tx_busy    = (state_q != StIdle) || !fifo_empty;
  assign tx_done    = (state_q == StStop) && period_end;
  assign uart_txd   = txd_q;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = period_end ? '0 : clk_cnt_q + 16'd1;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    txd_d     = txd_q;
    fifo_pop  = 1'b0;
`ifdef UART_SEND_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      StIdle: begin
        clk_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sh_d     = fifo_data;
          txd_d    = START_LVL;
          state_d  = StStart;
`ifdef UART_SEND_PARITY_EN
          par_d    = ^fifo_data;
`endif
        end
      end
      StStart: begin
        if (period_end) begin
          txd_d     = sh_q[0];
          bit_cnt_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (period_end) begin
          if (bit_cnt_q == LastBit) begin
`ifdef UART_SEND_PARITY_EN
            txd_d   = par_q;
            state_d = StParity;
`else
            txd_d   = STOP_LVL;
            state_d = StStop;
`endif
          end else begin
            sh_d      = sh_q >> 1;
            txd_d     = sh_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_SEND_PARITY_EN
      StParity: begin
        if (period_end) begin
          txd_d   = STOP_LVL;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (period_end) begin
          // Chain straight into the next start bit when more bytes are waiting.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sh_d     = fifo_data;
            txd_d    = START_LVL;
            state_d  = StStart;
`ifdef UART_SEND_PARITY_EN
            par_d    = ^fifo_data;
`endif
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d   = StIdle;
        clk_cnt_d = '0;
        txd_d     = STOP_LVL;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      txd_q     <= STOP_LVL;
`ifdef UART_SEND_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      txd_q     <= txd_d;
`ifdef UART_SEND_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule
